// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions used by the writeback stage and the
// MEM-stage bypass.
//   - writeback source selectors (WB_SEL_*)
//   - load funct3 encodings (FUNCT3_*)
//   - writeback FSM state type and slot record
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_CSR  = 2'd3;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WRITE   = 2'd1,
    WAIT_LD = 2'd2
  } wb_state_t;

  // Contents of the single writeback slot. offset/funct3 are only
  // meaningful while a load waits for its data.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] data;
    logic [1:0]  offset;
    logic [2:0]  funct3;
    logic        misalign;
  } wb_slot_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment and sign/zero extension.
// Shared between the writeback stage and the MEM-stage bypass.
// Ports:
//   word_i     raw 32-bit word returned by data memory
//   offset_i   byte offset within the word (address[1:0])
//   funct3_i   load width/sign; unknown encodings behave as LW
//   data_o     aligned, extended load result
//   misalign_o access is not naturally aligned
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word_i[{offset_i, 3'b000} +: 8];
    half_sel   = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o     = word_i;
    misalign_o = 1'b0;
    case (funct3_i)
      FUNCT3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: data_o = {24'd0, byte_sel};
      FUNCT3_LH: begin
        data_o     = {{16{half_sel[15]}}, half_sel};
        misalign_o = offset_i[0];
      end
      FUNCT3_LHU: begin
        data_o     = {16'd0, half_sel};
        misalign_o = offset_i[0];
      end
      default: begin
        data_o     = word_i;
        misalign_o = (offset_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: single-entry slot between MEM and the register file.
// Optional feature macro: WB_INSTRET_EN (64-bit retired-instruction counter;
// when undefined, instret is tied to zero).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          MEM-stage handshake
//   in_pc, in_rd_addr, in_rd_we, in_wb_sel, in_alu_result, in_csr_rdata,
//   in_funct3                  retiring instruction fields
//   dmem_rvalid, dmem_rdata    data-memory load response
//   rd_addr, rd_data, rd_we    register-file write port
//   ld_pending, ld_pending_rd  load-use hazard information
//   retire_valid, retire_pc    retire pulse and PC
//   load_misalign              pulse when a misaligned load is dropped
//   instret                    retired-instruction count
module wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_rd_we,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_csr_rdata,
  input  logic [2:0]      in_funct3,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_we,
  output logic            ld_pending,
  output logic [4:0]      ld_pending_rd,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic            load_misalign,
  output logic [63:0]     instret
);

  wb_state_t   state_q, state_d;
  wb_slot_t    slot_q, slot_d;
  logic        accept;
  logic        is_load;
  logic [31:0] ld_data;
  logic        ld_misalign;

  // The load's offset/funct3 are latched at accept; alignment happens on the
  // returning word so the slot never stores the raw memory data.
  load_align u_load_align (
    .word_i     (dmem_rdata),
    .offset_i   (slot_q.offset),
    .funct3_i   (slot_q.funct3),
    .data_o     (ld_data),
    .misalign_o (ld_misalign)
  );

  assign in_ready = (state_q != WAIT_LD);
  assign accept   = in_valid & in_ready;
  assign is_load  = (in_wb_sel == WB_SEL_LOAD);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      EMPTY, WRITE: begin
        if (accept) begin
          state_d         = is_load ? WAIT_LD : WRITE;
          slot_d.pc       = in_pc;
          slot_d.rd       = in_rd_addr;
          slot_d.rd_we    = in_rd_we;
          slot_d.offset   = in_alu_result[1:0];
          slot_d.funct3   = in_funct3;
          slot_d.misalign = 1'b0;
          case (in_wb_sel)
            WB_SEL_PC4: slot_d.data = in_pc + 32'd4;
            WB_SEL_CSR: slot_d.data = in_csr_rdata;
            default:    slot_d.data = in_alu_result;
          endcase
        end else begin
          state_d = EMPTY;
        end
      end
      WAIT_LD: begin
        if (dmem_rvalid) begin
          state_d         = WRITE;
          slot_d.data     = ld_data;
          slot_d.misalign = ld_misalign;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  assign rd_addr       = slot_q.rd;
  assign rd_data       = slot_q.data;
  assign rd_we         = (state_q == WRITE) & slot_q.rd_we & (slot_q.rd != 5'd0)
                         & ~slot_q.misalign;
  assign ld_pending    = (state_q == WAIT_LD);
  assign ld_pending_rd = ld_pending ? slot_q.rd : 5'd0;
  assign retire_valid  = (state_q == WRITE);
  assign retire_pc     = slot_q.pc;
  assign load_misalign = (state_q == WRITE) & slot_q.misalign;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (retire_valid) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_rd_addr = '0;
  logic        in_rd_we = 1'b0;
  logic [1:0]  in_wb_sel = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_csr_rdata = '0;
  logic [2:0]  in_funct3 = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'hDEAD_BEEF;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;
  logic        ld_pending;
  logic [4:0]  ld_pending_rd;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        load_misalign;
  logic [63:0] instret;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_csr_rdata(in_csr_rdata),
    .in_funct3(in_funct3), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
    .ld_pending(ld_pending), .ld_pending_rd(ld_pending_rd),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .load_misalign(load_misalign), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_issued = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_EN
    return 64'(n_issued);
`else
    return 64'd0;
`endif
  endfunction

  // Monitor: every retire pops one expected writeback.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_we && !retire_valid) chk("rd_we_without_retire", rd_we, 1'b0);
      if (retire_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", retire_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_we", rd_we, e.we);
          chk("rd_addr", rd_addr, e.rd);
          chk("retire_pc", retire_pc, e.pc);
          chk("load_misalign", load_misalign, e.mis);
          if (e.chk_data) chk("rd_data", rd_data, e.data);
        end
      end else begin
        chk("load_misalign_idle", load_misalign, 1'b0);
      end
    end
  end

  // Present one instruction; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] csr, input logic [2:0] f3,
                       input logic exp_we, input logic [31:0] exp_data,
                       input logic chk_data, input logic exp_mis);
    exp_t e;
    chk("in_ready_at_issue", in_ready, 1'b1);
    in_valid = 1'b1; in_pc = pc; in_rd_addr = rd; in_rd_we = we;
    in_wb_sel = sel; in_alu_result = alu; in_csr_rdata = csr; in_funct3 = f3;
    e.we = exp_we; e.rd = rd; e.data = exp_data; e.chk_data = chk_data;
    e.pc = pc; e.mis = exp_mis;
    sb.push_back(e);
    n_issued++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_alu_result = 32'h5A5A_5A5A;
  endtask

  task automatic do_load(input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] word, input logic exp_we,
                         input logic [31:0] exp_data, input logic exp_mis,
                         input int lat);
    issue(pc, rd, 1'b1, WB_SEL_LOAD, addr, 32'h0, f3, exp_we, exp_data, !exp_mis, exp_mis);
    for (int i = 0; i < lat - 1; i++) begin
      chk("in_ready_wait", in_ready, 1'b0);
      chk("ld_pending", ld_pending, 1'b1);
      chk("ld_pending_rd", ld_pending_rd, rd);
      @(posedge clk); #1;
    end
    dmem_rvalid = 1'b1; dmem_rdata = word;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rd_we", rd_we, 1'b0);
    chk("rst_retire", retire_valid, 1'b0);
    chk("rst_ld_pending", ld_pending, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_instret", instret, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU op
    issue(32'h0000_1000, 5'd5, 1'b1, WB_SEL_ALU, 32'h1234_5678, 32'h0, 3'b000,
          1'b1, 32'h1234_5678, 1'b1, 1'b0);
    @(posedge clk); #1;

    // LB / LBU at 0x103, data arrives 3 cycles after accept
    do_load(32'h0000_1004, 5'd7, 32'h0000_0103, FUNCT3_LB, 32'h80FF_0000,
            1'b1, 32'hFFFF_FF80, 1'b0, 3);
    do_load(32'h0000_1008, 5'd8, 32'h0000_0103, FUNCT3_LBU, 32'h80FF_0000,
            1'b1, 32'h0000_0080, 1'b0, 3);
    // Halfword forms
    do_load(32'h0000_100C, 5'd9, 32'h0000_0102, FUNCT3_LH, 32'h8001_1234,
            1'b1, 32'hFFFF_8001, 1'b0, 1);
    do_load(32'h0000_1010, 5'd10, 32'h0000_0100, FUNCT3_LHU, 32'h8001_9234,
            1'b1, 32'h0000_9234, 1'b0, 2);
    do_load(32'h0000_1014, 5'd11, 32'h0000_0200, FUNCT3_LW, 32'hCAFE_F00D,
            1'b1, 32'hCAFE_F00D, 1'b0, 1);
    // Misaligned: LW at 0x102 and LH at 0x101
    do_load(32'h0000_1018, 5'd12, 32'h0000_0102, FUNCT3_LW, 32'h1111_2222,
            1'b0, 32'h0, 1'b1, 2);
    do_load(32'h0000_101C, 5'd13, 32'h0000_0101, FUNCT3_LH, 32'h1111_2222,
            1'b0, 32'h0, 1'b1, 1);
    @(posedge clk); #1;

    // Three back-to-back ALU ops after a reset so instret starts at 0
    rst_n = 1'b0; sb.delete(); n_issued = 0;
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'h0000_2000, 5'd1, 1'b1, WB_SEL_ALU, 32'h0000_0011, 32'h0, 3'b000,
          1'b1, 32'h0000_0011, 1'b1, 1'b0);
    issue(32'h0000_2004, 5'd0, 1'b1, WB_SEL_ALU, 32'h0000_0022, 32'h0, 3'b000,
          1'b0, 32'h0000_0022, 1'b1, 1'b0);
    issue(32'h0000_2008, 5'd3, 1'b1, WB_SEL_CSR, 32'h0, 32'h0000_0033, 3'b000,
          1'b1, 32'h0000_0033, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("instret_b2b", instret, exp_instret());

    // JAL wrap and rd_we=0 instruction
    issue(32'hFFFF_FFFC, 5'd1, 1'b1, WB_SEL_PC4, 32'h0, 32'h0, 3'b000,
          1'b1, 32'h0000_0000, 1'b1, 1'b0);
    issue(32'h0000_3000, 5'd4, 1'b0, WB_SEL_ALU, 32'h0000_0044, 32'h0, 3'b000,
          1'b0, 32'h0000_0044, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("instret_more", instret, exp_instret());

    // Reset while waiting for load data; late rvalid must be ignored
    issue(32'h0000_4000, 5'd6, 1'b1, WB_SEL_LOAD, 32'h0000_0100, 32'h0, FUNCT3_LW,
          1'b1, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_pending", ld_pending, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; sb.delete(); n_issued = 0;
    #2;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_pending", ld_pending, 1'b0);
    chk("mid_rst_pending_rd", ld_pending_rd, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("late_rvalid_rd_we", rd_we, 1'b0);
    chk("late_rvalid_retire", retire_valid, 1'b0);
    chk("late_rvalid_in_ready", in_ready, 1'b1);
    chk("late_rvalid_pending", ld_pending, 1'b0);
    chk("late_rvalid_instret", instret, 64'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I pipeline, directly upstream of the register file.
- Accepts one retiring instruction per cycle from the MEM stage through a valid/ready handshake.
- For loads, waits for the data-memory response, then aligns and sign- or zero-extends the data.
- Selects the writeback source, drives the register-file write port (rd_addr/rd_data/rd_we), and exports load-use hazard and retire information.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_pc  in  32  PC of the instruction.
- in_rd_addr  in  5  destination register.
- in_rd_we  in  1  instruction writes rd.
- in_wb_sel  in  2  writeback source: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR.
- in_alu_result  in  32  ALU result; for loads, the effective address.
- in_csr_rdata  in  32  CSR old value.
- in_funct3  in  3  load width/sign (LB, LH, LW, LBU, LHU).
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data word.
- rd_addr  out  5  to register file.
- rd_data  out  32  to register file.
- rd_we  out  1  to register file.
- ld_pending  out  1  load waiting for data.
- ld_pending_rd  out  5  rd of that load.
- retire_valid  out  1  one-cycle pulse per retired instruction.
- retire_pc  out  32  PC of the retired instruction.
- load_misalign  out  1  one-cycle pulse: misaligned load dropped.
- instret  out  64  retired-instruction count.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. State EMPTY, slot cleared. Reset mid-load discards the slot; a late dmem_rvalid after reset is ignored.
- States:
  - EMPTY: slot empty; in_ready=1.
  - WRITE: slot holds a result; in_ready=1.
  - WAIT_LD: slot holds a load without data; in_ready=0.
- Transitions:
  - Accept (in_valid & in_ready) with wb_sel≠LOAD → WRITE.
  - Accept with wb_sel=LOAD → WAIT_LD.
  - No accept from WRITE → EMPTY.
  - WAIT_LD & dmem_rvalid → WRITE, capturing the aligned data.
- Back-to-back: accepts are allowed while in WRITE, giving throughput of one instruction per cycle.
- Latency:
  - Accept in cycle N → rd_we/retire_valid high in cycle N+1.
  - dmem_rvalid in cycle M → write in cycle M+1.
- rd_we = (state==WRITE) & slot_rd_we & (slot_rd≠0) & ~slot_misalign. rd_addr and rd_data are held from the slot and are valid whenever state==WRITE.
- Writeback source:
  - ALU → alu_result.
  - PC+4 → pc+4, wrapping mod 2^32.
  - CSR → csr_rdata.
  - LOAD → aligned data.
- Load alignment: offset = alu_result[1:0].
  - LB/LBU select byte[offset].
  - LH/LHU select halfword[offset[1]].
  - Sign- or zero-extend per funct3.
  - Undefined funct3 is treated as LW.
- Misalignment:
  - LH/LHU with offset[0]=1, or LW with offset≠0, is misaligned.
  - A misaligned load is still accepted and still waits for dmem_rvalid.
  - In WRITE: rd_we=0, load_misalign=1 for one cycle, and retire_valid=1.
- ld_pending = (state==WAIT_LD). ld_pending_rd = slot rd, or 0 when not pending.
- dmem_rvalid outside WAIT_LD is ignored. The MEM stage guarantees rvalid no earlier than the cycle after the accept.
- retire_valid is asserted in every WRITE cycle; retire_pc = slot pc.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: instret is a 64-bit counter, incremented by 1 on each retire_valid, wrapping at 2^64; reset value 0.
- Undefined: instret is tied to 0 and no counter flops are present.

Decomposition:
- Shared package riscv_pkg holds:
  - WB_SEL_ALU/LOAD/PC4/CSR constants.
  - FUNCT3_LB/LH/LW/LBU/LHU constants.
  - wb_state_t enum {EMPTY, WRITE, WAIT_LD}.
- One combinational sub-module, load_align: inputs word, offset, funct3; outputs data, misalign. It is reused by the MEM-stage bypass.

Test Plan:
- ALU op, rd=5, result 0x1234_5678, accepted in cycle 0 → cycle 1: rd_we=1, rd_addr=5, rd_data=0x12345678, retire_valid=1.
- LB at address 0x103 with dmem_rdata=0x80FF_0000 arriving 3 cycles after accept:
  - in_ready=0 and ld_pending=1 with ld_pending_rd=rd while waiting.
  - In the cycle after rvalid, rd_data=0xFFFF_FF80.
  - Repeat as LBU → rd_data=0x0000_0080.
- LW at address 0x102 → load_misalign pulse and retire_valid=1 in the same cycle; rd_we=0; register file untouched.
- Three back-to-back ALU ops, the middle one with rd=0:
  - rd_we pattern is 1,0,1 over cycles 1..3.
  - in_ready stays 1.
  - With WB_INSTRET_EN defined, instret=3.
- JAL with pc=0xFFFF_FFFC and wb_sel=PC+4 → rd_data=0x0000_0000.
- Assert rst_n low while in WAIT_LD, then drive dmem_rvalid after release → no rd_we, state EMPTY, in_ready=1, instret=0.
